// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, oversample default and
// status-register bit positions used by the RX/TX engines and register file.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int OVS_DEFAULT = 8;

    localparam int STAT_FRAME_BIT   = 0;
    localparam int STAT_PARITY_BIT  = 1;
    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_EMPTY_BIT   = 3;
    localparam int STAT_FULL_BIT    = 4;

    // Expected parity bit: even parity makes the total number of ones even.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding received characters.
// Head reads as zero while empty; a push into a full FIFO without a pop is dropped.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign do_pop    = pop_i & ~empty_o;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push_i & (~full_o | do_pop);
    assign overrun_o = push_i & full_o & ~do_pop;
    assign count_o   = count_q;
    assign dout_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes the serial line, oversamples with a
// phase-accumulator tick, deframes 8N1 / 8+parity characters into a small FIFO.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int OVS        = OVS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [31:0]                   baud_inc_i,
    input  logic                          rx_en_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          uart_rx,
    input  logic                          rd_i,
    input  logic                          clr_flags_i,
    output logic [7:0]                    dat_o,
    output logic                          rx_empty_o,
    output logic                          rx_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o,
    output logic                          busy_o
);

    localparam int TC_W = $clog2(OVS);
    localparam logic [TC_W-1:0] TC_HALF = TC_W'(OVS / 2 - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVS - 1);

    rx_state_e   state_q, state_d;
    logic        sync1_q, sync2_q, prev_q;
    logic [31:0] acc_q, acc_d;
    logic [32:0] acc_sum;
    logic        tick;
    logic [TC_W-1:0] tc_q, tc_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_en_q, par_en_d;
    logic        par_odd_q, par_odd_d;
    logic        push_q, push_d;
    logic        frame_err_q, frame_err_d;
    logic        parity_err_q, parity_err_d;
    logic        overrun_q, overrun_d;
    logic        frame_set, parity_set, fifo_overrun;

    assign acc_sum = {1'b0, acc_q} + {1'b0, baud_inc_i};
    assign tick    = acc_sum[32];

    // Two flops for metastability, one more to remember the previous level.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_sum[31:0];
        tc_d         = tc_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        push_d       = 1'b0;
        frame_set    = 1'b0;
        parity_set   = 1'b0;

        if (!rx_en_i) begin
            state_d = ST_IDLE;
            tc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_d   = ST_START;
                        tc_d      = '0;
                        acc_d     = '0;
                        par_en_d  = parity_en_i;
                        par_odd_d = parity_odd_i;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tc_q == TC_HALF) begin
                            tc_d      = '0;
                            bit_idx_d = '0;
                            state_d   = sync2_q ? ST_IDLE : ST_DATA;
                        end else begin
                            tc_d = tc_q + TC_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (tc_q == TC_LAST) begin
                            tc_d    = '0;
                            shift_d = {sync2_q, shift_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_d = par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 3'd1;
                            end
                        end else begin
                            tc_d = tc_q + TC_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (tc_q == TC_LAST) begin
                            tc_d       = '0;
                            parity_set = (sync2_q != calc_parity(shift_q, par_odd_q));
                            state_d    = ST_STOP;
                        end else begin
                            tc_d = tc_q + TC_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (tc_q == TC_LAST) begin
                            tc_d      = '0;
                            frame_set = ~sync2_q;
                            push_d    = sync2_q;
                            state_d   = ST_IDLE;
                        end else begin
                            tc_d = tc_q + TC_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tc_d    = '0;
                end
            endcase
        end

        // Set beats clear so an event coinciding with a clear is not lost.
        frame_err_d  = frame_set    | (frame_err_q  & ~clr_flags_i);
        parity_err_d = parity_set   | (parity_err_q & ~clr_flags_i);
        overrun_d    = fifo_overrun | (overrun_q    & ~clr_flags_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            tc_q         <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            tc_q         <= tc_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // shift_q is stable for many cycles after the stop sample, so the delayed push can use it directly.
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push_q),
        .din_i     (shift_q),
        .pop_i     (rd_i),
        .dout_o    (dat_o),
        .empty_o   (rx_empty_o),
        .full_o    (rx_full_o),
        .count_o   (rx_count_o),
        .overrun_o (fifo_overrun)
    );

    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: 32 clocks per bit, frames driven on the
// falling clock edge, outputs sampled on the falling edge.
module tb_uart_rx_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] baud_inc_i;
    logic        rx_en_i, parity_en_i, parity_odd_i, uart_rx, rd_i, clr_flags_i;
    logic [7:0]  dat_o;
    logic        rx_empty_o, rx_full_o, frame_err_o, parity_err_o, overrun_o, busy_o;
    logic [2:0]  rx_count_o;

    int checks   = 0;
    int failures = 0;
    int fall_c;

    always #5 clk_i = ~clk_i;

    uart_rx_engine #(.OVS(8), .FIFO_DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .baud_inc_i   (baud_inc_i),
        .rx_en_i      (rx_en_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .uart_rx      (uart_rx),
        .rd_i         (rd_i),
        .clr_flags_i  (clr_flags_i),
        .dat_o        (dat_o),
        .rx_empty_o   (rx_empty_o),
        .rx_full_o    (rx_full_o),
        .rx_count_o   (rx_count_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    // pulse_kind: 0 none, 1 rd_i, 2 clr_flags_i, asserted for the cycle at offset pulse_at.
    // The push cycle of a frame is 307 cycles after its start (339 with parity).
    task automatic send_frame(input logic [7:0] b, input logic use_par, input logic par_bit,
                              input logic stop_bit, input int pulse_at, input int pulse_kind,
                              input int idle_cycles);
        logic [10:0] fr;
        logic [3:0]  idx;
        int          nb;
        if (use_par) begin
            fr = {stop_bit, par_bit, b, 1'b0};
            nb = 11;
        end else begin
            fr = {1'b1, stop_bit, b, 1'b0};
            nb = 10;
        end
        fall_c = -1;
        for (int c = 0; c < nb * 32; c++) begin
            if (rx_empty_o === 1'b0 && fall_c < 0) fall_c = c;
            idx         = 4'(c / 32);
            uart_rx     = fr[idx];
            rd_i        = (pulse_kind == 1) && (c == pulse_at);
            clr_flags_i = (pulse_kind == 2) && (c == pulse_at);
            @(negedge clk_i);
        end
        rd_i        = 1'b0;
        clr_flags_i = 1'b0;
        uart_rx     = 1'b1;
        repeat (idle_cycles) @(negedge clk_i);
    endtask

    task automatic pop_one;
        rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
    endtask

    task automatic pulse_clr;
        clr_flags_i = 1'b1;
        @(negedge clk_i);
        clr_flags_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({dat_o, rx_empty_o, rx_full_o, rx_count_o} !== {8'h00, 1'b1, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_fifo: dat=%h empty=%b full=%b count=%0d, want 00/1/0/0",
                     dat_o, rx_empty_o, rx_full_o, rx_count_o);
        end
        checks++;
        if ({frame_err_o, parity_err_o, overrun_o, busy_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: fe/pe/ov/busy=%b%b%b%b, want 0000",
                     frame_err_o, parity_err_o, overrun_o, busy_o);
        end
        $display("reset: empty=%b count=%0d busy=%b", rx_empty_o, rx_count_o, busy_o);
    endtask

    task automatic test_single_byte;
        send_frame(8'h61, 1'b0, 1'b0, 1'b1, 0, 0, 16);
        checks++;
        if (fall_c < 0 || fall_c > 309) begin
            failures++;
            $display("FAIL single_latency: empty fell at cycle %0d, want 0..309", fall_c);
        end
        checks++;
        if ({dat_o, rx_empty_o, rx_count_o} !== {8'h61, 1'b0, 3'd1}) begin
            failures++;
            $display("FAIL single_data: dat=%h empty=%b count=%0d, want 61/0/1",
                     dat_o, rx_empty_o, rx_count_o);
        end
        checks++;
        if ({frame_err_o, parity_err_o, overrun_o} !== 3'b000) begin
            failures++;
            $display("FAIL single_flags: fe/pe/ov=%b%b%b, want 000", frame_err_o, parity_err_o, overrun_o);
        end
        pop_one();
        checks++;
        if ({dat_o, rx_empty_o} !== {8'h00, 1'b1}) begin
            failures++;
            $display("FAIL single_pop: dat=%h empty=%b, want 00/1", dat_o, rx_empty_o);
        end
        $display("single: byte 61 latency=%0d clk", fall_c);
    endtask

    task automatic test_burst;
        logic [7:0] exp_b;
        for (int i = 0; i < 4; i++) send_frame(8'h61 + 8'(i), 1'b0, 1'b0, 1'b1, 0, 0, 0);
        checks++;
        if ({rx_full_o, rx_count_o, overrun_o} !== {1'b1, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL burst_full: full=%b count=%0d ov=%b, want 1/4/0", rx_full_o, rx_count_o, overrun_o);
        end
        send_frame(8'h65, 1'b0, 1'b0, 1'b1, 0, 0, 8);
        checks++;
        if ({overrun_o, rx_count_o} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL burst_overrun: ov=%b count=%0d, want 1/4", overrun_o, rx_count_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h61 + 8'(i);
            checks++;
            if (dat_o !== exp_b) begin
                failures++;
                $display("FAIL burst_read%0d: dat=%h, want %h", i, dat_o, exp_b);
            end
            pop_one();
        end
        checks++;
        if (rx_empty_o !== 1'b1) begin
            failures++;
            $display("FAIL burst_drain: empty=%b, want 1", rx_empty_o);
        end
        pulse_clr();
        $display("burst: 5 frames, 4 read back, overrun seen");
    endtask

    task automatic test_framing;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 0, 0, 32);
        checks++;
        if ({frame_err_o, rx_empty_o} !== 2'b11) begin
            failures++;
            $display("FAIL frame_err: fe=%b empty=%b, want 1/1", frame_err_o, rx_empty_o);
        end
        send_frame(8'h41, 1'b0, 1'b0, 1'b1, 0, 0, 8);
        checks++;
        if ({dat_o, rx_count_o} !== {8'h41, 3'd1}) begin
            failures++;
            $display("FAIL frame_recover: dat=%h count=%0d, want 41/1", dat_o, rx_count_o);
        end
        pulse_clr();
        checks++;
        if (frame_err_o !== 1'b0) begin
            failures++;
            $display("FAIL frame_clear: fe=%b, want 0", frame_err_o);
        end
        pop_one();
        $display("framing: bad stop flagged, 41 recovered, flag cleared");
    endtask

    task automatic test_parity;
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 0, 0, 8);
        checks++;
        if ({dat_o, rx_count_o, parity_err_o} !== {8'h07, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL parity_bad: dat=%h count=%0d pe=%b, want 07/1/1", dat_o, rx_count_o, parity_err_o);
        end
        pulse_clr();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 0, 0, 8);
        checks++;
        if ({rx_count_o, parity_err_o, frame_err_o} !== {3'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL parity_good: count=%0d pe=%b fe=%b, want 2/0/0", rx_count_o, parity_err_o, frame_err_o);
        end
        parity_en_i = 1'b0;
        $display("parity: even parity error detected, correct parity accepted");
    endtask

    task automatic test_glitch;
        uart_rx = 1'b0;
        @(negedge clk_i);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start: busy=%b, want 1", busy_o);
        end
        repeat (36) @(negedge clk_i);
        checks++;
        if ({busy_o, rx_count_o} !== {1'b0, 3'd2}) begin
            failures++;
            $display("FAIL glitch_filter: busy=%b count=%0d, want 0/2", busy_o, rx_count_o);
        end
        $display("glitch: short low pulse rejected");
    endtask

    task automatic test_reset_midframe;
        logic [9:0] fr;
        logic [3:0] idx;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int c = 0; c < 171; c++) begin
            idx     = 4'(c / 32);
            uart_rx = fr[idx];
            rst_i   = (c != 170);
            @(negedge clk_i);
        end
        rst_i   = 1'b1;
        uart_rx = 1'b1;
        checks++;
        if ({busy_o, rx_empty_o, rx_count_o, dat_o} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
            failures++;
            $display("FAIL midreset_state: busy=%b empty=%b count=%0d dat=%h, want 0/1/0/00",
                     busy_o, rx_empty_o, rx_count_o, dat_o);
        end
        checks++;
        if ({frame_err_o, parity_err_o, overrun_o} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_flags: fe/pe/ov=%b%b%b, want 000", frame_err_o, parity_err_o, overrun_o);
        end
        repeat (40) @(negedge clk_i);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 0, 0, 8);
        checks++;
        if ({dat_o, rx_count_o} !== {8'h3C, 3'd1}) begin
            failures++;
            $display("FAIL midreset_next: dat=%h count=%0d, want 3c/1", dat_o, rx_count_o);
        end
        pop_one();
        $display("midreset: partial A5 discarded, 3C received after");
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp_b;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b1, 0, 0, 0);
        send_frame(8'h15, 1'b0, 1'b0, 1'b1, 307, 1, 4);
        checks++;
        if ({rx_count_o, overrun_o, dat_o} !== {3'd4, 1'b0, 8'h12}) begin
            failures++;
            $display("FAIL sim_pushpop: count=%0d ov=%b dat=%h, want 4/0/12", rx_count_o, overrun_o, dat_o);
        end
        send_frame(8'h16, 1'b0, 1'b0, 1'b1, 307, 2, 4);
        checks++;
        if ({overrun_o, rx_count_o} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL sim_setclr: ov=%b count=%0d, want 1/4", overrun_o, rx_count_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h12 + 8'(i);
            checks++;
            if (dat_o !== exp_b) begin
                failures++;
                $display("FAIL sim_read%0d: dat=%h, want %h", i, dat_o, exp_b);
            end
            pop_one();
        end
        pulse_clr();
        checks++;
        if ({overrun_o, rx_empty_o} !== 2'b01) begin
            failures++;
            $display("FAIL sim_final: ov=%b empty=%b, want 0/1", overrun_o, rx_empty_o);
        end
        $display("simultaneous: push+pop when full kept count, set beat clear");
    endtask

    initial begin
        rst_i        = 1'b0;
        baud_inc_i   = 32'h4000_0000;
        rx_en_i      = 1'b1;
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
        uart_rx      = 1'b1;
        rd_i         = 1'b0;
        clr_flags_i  = 1'b0;
        @(negedge clk_i);
        test_reset();
        repeat (8) @(negedge clk_i);
        test_single_byte();
        test_burst();
        test_framing();
        test_parity();
        test_glitch();
        test_reset_midframe();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Serial receive engine for the UART peripheral. It is the receive-direction counterpart of the TX path. It samples the uart_rx line using the same 32-bit phase-accumulator baud constant that software writes for TX. It deframes 8N1 or 8-bit-plus-parity characters and buffers them in a small FIFO that the wishbone register file reads. It sits beside the TX engine inside the UART interface and exports status flags for the RX control and status register.

Parameters:
OVS, 8, oversample ticks per bit period (power of two, >=4)
FIFO_DEPTH, 4, receive buffer entries (power of two)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-low
baud_inc_i  in  32  phase-accumulator increment; each carry-out is one oversample tick
rx_en_i  in  1  receiver enable; low forces IDLE, FIFO retained
parity_en_i  in  1  expect parity bit after data
parity_odd_i  in  1  1=odd parity, 0=even parity
uart_rx  in  1  asynchronous serial input, idle high
rd_i  in  1  pop FIFO head (one-cycle pulse)
clr_flags_i  in  1  clear sticky error flags
dat_o  out  8  FIFO head byte (first-word fall-through); 0x00 when empty
rx_empty_o  out  1  FIFO empty
rx_full_o  out  1  FIFO full
rx_count_o  out  $clog2(FIFO_DEPTH)+1  entries held
frame_err_o  out  1  sticky: stop bit sampled low
parity_err_o  out  1  sticky: parity mismatch
overrun_o  out  1  sticky: byte arrived while FIFO full
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i==0 at clk edge):
  - state IDLE; accumulator, tick counter, shift register and FIFO pointers cleared.
  - dat_o=0x00, rx_empty_o=1, rx_full_o=0, rx_count_o=0, all error flags 0, busy_o=0.
  - Reset mid-frame discards the partial character.
- Input sync: uart_rx passes through a 2-flop synchronizer, plus one more flop for edge detect. All decisions use the synchronized value.
- Baud tick: acc <= acc + baud_inc_i every cycle; tick = carry out of bit 31.
  - acc is zeroed on start-edge detection to phase-align sampling.
  - baud_inc_i==0 produces no ticks; the FSM stalls in its current state.
- FSM states: IDLE, START, DATA, PARITY, STOP. Tick counter tc counts ticks within a bit.
  - IDLE: on synchronized falling edge (prev 1, cur 0) and rx_en_i=1 -> START, tc=0. A line held low never re-triggers; an edge is required.
  - START: on tick with tc==OVS/2-1, sample. If 1 (glitch) -> IDLE, no flag. If 0 -> DATA, tc=0, bit index=0.
  - DATA: on tick with tc==OVS-1, sample into shift register LSB-first. After bit 7 -> PARITY if parity_en_i, else STOP.
  - PARITY: sample at tc==OVS-1. Compare with XOR(data) ^ parity_odd_i; mismatch sets parity_err_o. -> STOP.
  - STOP: sample at tc==OVS-1.
    - If 0: set frame_err_o, discard byte.
    - If 1: push byte (parity-errored bytes are still pushed).
    - Either way -> IDLE on that cycle.
  - rx_en_i low in any state -> IDLE next cycle.
- Push timing: FIFO write occurs the cycle after the stop-bit sample. rx_empty_o falls the following cycle.
- FIFO rules:
  - Push when full with no pop in the same cycle: byte dropped, overrun_o set.
  - Push and pop in the same cycle: both take effect, count unchanged, including when full (no overrun).
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clr_flags_i clears all three. A set event in the same cycle as clr_flags_i wins (flag ends at 1).
- parity_en_i and parity_odd_i are sampled at the start edge and held for the frame.

Decomposition:
- Package uart_pkg: FSM state enum, OVS default, flag bit positions for the status register (frame=0, parity=1, overrun=2, empty=3, full=4), shared with the TX engine and register file.
- One sub-module: uart_rx_fifo (synchronous FWFT FIFO with count, full and empty).
- FSM, synchronizer and accumulator stay in uart_rx_engine.

Test Plan:
- Single byte: clk 10 ns, baud_inc_i=0x40000000, OVS=8 (32 clk/bit); drive 8N1 frame 0x61 -> rx_empty_o falls within 9.5 bits + 5 clk of start edge; dat_o=0x61, no flags; rd_i pulse -> rx_empty_o=1, dat_o=0x00.
- Burst/overrun: send 0x61,0x62,0x63,0x64,0x65 back-to-back with no reads -> rx_full_o=1 after 4th, rx_count_o=4, overrun_o=1 after 5th; reads return 0x61..0x64 in order.
- Framing: frame 0x55 with stop bit driven 0 -> frame_err_o=1, FIFO stays empty. Line returns high, next 0x41 received correctly. clr_flags_i -> frame_err_o=0.
- Parity: parity_en_i=1, parity_odd_i=0, send 0x07 with parity bit 0 (wrong) -> 0x07 pushed, parity_err_o=1. Correct parity 1 on next frame -> no new flag.
- Glitch and reset: 1-clk-wide low pulse (filtered before tick mid-point) -> busy_o returns 0, nothing pushed. Separately, assert rst_i=0 during DATA bit 4 -> next cycle busy_o=0, FIFO empty, flags 0.
- Simultaneous events: FIFO full with rd_i coinciding with push cycle -> count stays 4, overrun_o=0. clr_flags_i coinciding with overrun set -> overrun_o=1.
